// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game score path.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2
    } game_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [9:0] BIRD_X_DEFAULT = 10'd200;

    // Per-cycle pass count is at most four channels, so three bits suffice.
    localparam int PASS_CNT_W = 3;

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational DIGITS-digit BCD plus small binary increment, saturating at all nines.
module bcd_add_sat
    import flappy_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int INC_W  = PASS_CNT_W
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [INC_W-1:0]    inc,
    output logic [4*DIGITS-1:0] sum
);

    logic [4*DIGITS-1:0] raw;
    logic [INC_W-1:0]    carry;
    logic [4:0]          dsum;
    bcd_digit_t          digit;

    // The increment enters as the carry into digit 0; after that the carry is 0 or 1.
    always_comb begin
        raw   = '0;
        carry = inc;
        dsum  = '0;
        digit = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dsum = {1'b0, a[4*d +: 4]} + 5'(carry);
            if (dsum >= 5'd10) begin
                digit = 4'(dsum - 5'd10);
                carry = INC_W'(1);
            end else begin
                digit = dsum[3:0];
                carry = '0;
            end
            raw[4*d +: 4] = digit;
        end
        sum = (carry != '0) ? {DIGITS{4'h9}} : raw;
    end

endmodule

// File: rtl/score_tracker.sv
// Flappy score tracker: counts pipe crossings past the bird in saturating BCD.
// Optional high-score register enabled by defining SCORE_TRACKER_HISCORE_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for game_start
// PLAYING | game running, pipe crossings add to the score
// DEAD    | bird hit something, score frozen until game_start
module score_tracker
    import flappy_pkg::*;
#(
    parameter int                  NUM_PIPES    = 2,
    parameter int                  PIPE_X_W     = 10,
    parameter int                  SCORE_DIGITS = 3,
    parameter logic [PIPE_X_W-1:0] BIRD_X       = PIPE_X_W'(BIRD_X_DEFAULT)
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               game_start,
    input  logic                               bird_killed,
    input  logic [NUM_PIPES-1:0]               pipe_valid,
    input  logic [NUM_PIPES-1:0][PIPE_X_W-1:0] pipe_x,
    output logic [4*SCORE_DIGITS-1:0]          score_bcd,
    output logic [4*SCORE_DIGITS-1:0]          high_score_bcd,
    output logic                               score_pulse,
    output logic                               new_high,
    output logic [1:0]                         state_o
);

    localparam int SW = 4*SCORE_DIGITS;

    game_state_e                        state;
    logic [NUM_PIPES-1:0][PIPE_X_W-1:0] prev_x;
    logic [NUM_PIPES-1:0]               prev_valid;
    logic [NUM_PIPES-1:0]               pass;
    logic [PASS_CNT_W-1:0]              pass_cnt;
    logic [SW-1:0]                      score_sum;
    logic [SW-1:0]                      score_next;
    logic                               enter_play;
    logic                               die;

    // A pipe that appears already left of the bird was never seen crossing,
    // so a pass also needs the channel to have been valid last cycle.
    always_comb begin
        pass     = '0;
        pass_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pass[i]  = (state == PLAYING) && pipe_valid[i] && prev_valid[i] &&
                       (prev_x[i] > BIRD_X) && (pipe_x[i] <= BIRD_X);
            pass_cnt = pass_cnt + PASS_CNT_W'(pass[i]);
        end
    end

    bcd_add_sat #(
        .DIGITS (SCORE_DIGITS),
        .INC_W  (PASS_CNT_W)
    ) u_add (
        .a   (score_bcd),
        .inc (pass_cnt),
        .sum (score_sum)
    );

    always_comb begin
        enter_play = game_start && (state != PLAYING);
        die        = bird_killed && (state == PLAYING);
        score_next = score_bcd;
        if (enter_play) begin
            score_next = '0;
        end else if ((state == PLAYING) && !bird_killed) begin
            score_next = score_sum;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            score_bcd   <= '0;
            score_pulse <= 1'b0;
            prev_x      <= '1;
            prev_valid  <= '0;
        end else begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                prev_x[i] <= pipe_valid[i] ? pipe_x[i] : '1;
            end
            prev_valid  <= pipe_valid;
            score_bcd   <= score_next;
            score_pulse <= (score_next != score_bcd);
            case (state)
                IDLE:    if (game_start)  state <= PLAYING;
                PLAYING: if (bird_killed) state <= DEAD;
                DEAD:    if (game_start)  state <= PLAYING;
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o = state;

`ifdef SCORE_TRACKER_HISCORE_EN
    logic [SW-1:0] high_q;
    logic          new_high_q;

    // BCD digits order the same way as binary, so a plain compare ranks scores.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else if (enter_play) begin
            new_high_q <= 1'b0;
        end else if (die && (score_bcd > high_q)) begin
            high_q     <= score_bcd;
            new_high_q <= 1'b1;
        end
    end

    assign high_score_bcd = high_q;
    assign new_high       = new_high_q;
`else
    assign high_score_bcd = '0;
    assign new_high       = 1'b0;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Randomised and directed bench for score_tracker against an integer game model.
module tb_score_tracker;

    localparam int NP   = 2;
    localparam int XW   = 10;
    localparam int SD   = 3;
    localparam int BX   = 200;
    localparam int MAXS = 999;

    logic                  Clk = 1'b0;
    logic                  Reset_n = 1'b0;
    logic                  game_start = 1'b0;
    logic                  bird_killed = 1'b0;
    logic [NP-1:0]         pipe_valid = '0;
    logic [NP-1:0][XW-1:0] pipe_x = '0;
    logic [4*SD-1:0]       score_bcd, high_score_bcd;
    logic                  score_pulse, new_high;
    logic [1:0]            state_o;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 playing, 2 dead; score held as a plain integer
    int m_state, m_score, m_high;
    int m_prev [NP];
    bit m_pv   [NP];
    bit m_pulse, m_new_high;

    always #5 Clk = ~Clk;

    score_tracker dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .game_start     (game_start),
        .bird_killed    (bird_killed),
        .pipe_valid     (pipe_valid),
        .pipe_x         (pipe_x),
        .score_bcd      (score_bcd),
        .high_score_bcd (high_score_bcd),
        .score_pulse    (score_pulse),
        .new_high       (new_high),
        .state_o        (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        int r = 0;
        for (int d = 0; d < SD; d++) begin
            r = r | ((v % 10) << (4*d));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit hiscore_en();
`ifdef SCORE_TRACKER_HISCORE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_high = 0; m_pulse = 0; m_new_high = 0;
        for (int i = 0; i < NP; i++) begin
            m_prev[i] = (1 << XW) - 1;
            m_pv[i]   = 0;
        end
    endtask

    task automatic model_edge();
        int passes = 0;
        int nscore = m_score;
        for (int i = 0; i < NP; i++)
            if (m_state == 1 && pipe_valid[i] && m_pv[i] && m_prev[i] > BX && int'(pipe_x[i]) <= BX)
                passes++;
        if (m_state != 1) begin
            if (game_start) begin
                m_state = 1; nscore = 0; m_new_high = 0;
            end
        end else if (bird_killed) begin
            m_state = 2;
            if (hiscore_en() && m_score > m_high) begin
                m_high = m_score; m_new_high = 1;
            end
        end else begin
            nscore = (m_score + passes > MAXS) ? MAXS : m_score + passes;
        end
        m_pulse = (nscore != m_score);
        m_score = nscore;
        for (int i = 0; i < NP; i++) begin
            m_pv[i]   = pipe_valid[i];
            m_prev[i] = pipe_valid[i] ? int'(pipe_x[i]) : (1 << XW) - 1;
        end
    endtask

    task automatic check_all();
        check("state", 32'(state_o), 32'(m_state));
        check("score", 32'(score_bcd), 32'(to_bcd(m_score)));
        check("pulse", 32'(score_pulse), 32'(m_pulse));
        check("high", 32'(high_score_bcd), 32'(to_bcd(m_high)));
        check("new_high", 32'(new_high), 32'(m_new_high));
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    task automatic set_pipe(input int i, input bit v, input int x);
        pipe_valid[i] = v;
        pipe_x[i]     = XW'(x);
    endtask

    task automatic start_game();
        game_start = 1'b1; step(); game_start = 1'b0;
    endtask

    task automatic async_reset();
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_score", 32'(score_bcd), 32'd0);
        check("rst_pulse", 32'(score_pulse), 32'd0);
        check("rst_high", 32'(high_score_bcd), 32'd0);
        check("rst_new_high", 32'(new_high), 32'd0);
        model_reset();
        @(posedge Clk);
        #3 Reset_n = 1'b1;
    endtask

    initial begin
        int pos [NP];
        model_reset();

        // power-on reset
        repeat (2) @(posedge Clk);
        #1;
        check_all();
        #2 Reset_n = 1'b1;

        // single pipe jumps 205 -> 195 past the bird
        set_pipe(1, 0, 0);
        start_game();
        set_pipe(0, 1, 205); step();
        set_pipe(0, 1, 195); step();
        check("s1_score", 32'(score_bcd), 32'h001);
        check("s1_pulse", 32'(score_pulse), 32'd1);
        step();
        check("s1_pulse_off", 32'(score_pulse), 32'd0);

        // both channels cross together
        set_pipe(0, 1, 201); set_pipe(1, 1, 201); step();
        set_pipe(0, 1, 200); set_pipe(1, 1, 200); step();
        check("s2_score", 32'(score_bcd), 32'h003);
        check("s2_pulse", 32'(score_pulse), 32'd1);
        step();
        check("s2_pulse_off", 32'(score_pulse), 32'd0);

        // reach 4, then pass and kill in the same cycle
        set_pipe(1, 0, 0);
        set_pipe(0, 1, 201); step();
        set_pipe(0, 1, 200); step();
        set_pipe(0, 1, 201); step();
        set_pipe(0, 1, 200); bird_killed = 1'b1; step();
        bird_killed = 1'b0;
        check("s4_score", 32'(score_bcd), 32'h004);
        check("s4_state", 32'(state_o), 32'd2);
        check("s4_high", 32'(high_score_bcd), hiscore_en() ? 32'h004 : 32'h0);
        check("s4_new_high", 32'(new_high), hiscore_en() ? 32'd1 : 32'd0);
        set_pipe(0, 1, 201); step();
        set_pipe(0, 1, 195); step();
        check("dead_no_score", 32'(score_bcd), 32'h004);

        // wrap then re-appear left of the bird
        start_game();
        set_pipe(0, 1, 3);   step();
        set_pipe(0, 1, 639); step();
        set_pipe(0, 0, 639); step();
        set_pipe(0, 1, 150); step();
        step();
        check("s5_score", 32'(score_bcd), 32'h000);

        // random play
        for (int i = 0; i < NP; i++) pos[i] = $urandom_range(150, 639);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NP; i++) begin
                pos[i] -= $urandom_range(0, 3);
                if (pos[i] < 0) pos[i] = $urandom_range(400, 639);
                if ($urandom_range(0, 29) == 0) pipe_valid[i] = ~pipe_valid[i];
                pipe_x[i] = XW'(pos[i]);
            end
            game_start  = ($urandom_range(0, 24) == 0);
            bird_killed = ($urandom_range(0, 59) == 0);
            step();
        end
        game_start = 1'b0; bird_killed = 1'b0;

        // reset mid-game at score 12
        async_reset();
        set_pipe(1, 0, 0);
        start_game();
        for (int k = 0; k < 12; k++) begin
            set_pipe(0, 1, 201); step();
            set_pipe(0, 1, 200); step();
        end
        check("s6_pre", 32'(score_bcd), 32'h012);
        async_reset();
        set_pipe(0, 1, 201); step();
        set_pipe(0, 1, 200); step();
        check("s6_score", 32'(score_bcd), 32'h000);
        check("s6_state", 32'(state_o), 32'd0);

        // saturation at 999
        start_game();
        for (int k = 0; k < 499; k++) begin
            set_pipe(0, 1, 201); set_pipe(1, 1, 201); step();
            set_pipe(0, 1, 200); set_pipe(1, 1, 200); step();
        end
        check("s3_998", 32'(score_bcd), 32'h998);
        set_pipe(0, 1, 201); set_pipe(1, 1, 201); step();
        set_pipe(0, 1, 200); set_pipe(1, 1, 200); step();
        check("s3_sat", 32'(score_bcd), 32'h999);
        check("s3_sat_pulse", 32'(score_pulse), 32'd1);
        set_pipe(1, 0, 0);
        set_pipe(0, 1, 201); step();
        set_pipe(0, 1, 200); step();
        check("s3_hold", 32'(score_bcd), 32'h999);
        check("s3_no_pulse", 32'(score_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
